// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic PORT_CORE   = 1'b0;
    localparam logic PORT_LOADER = 1'b1;
    localparam int   WAIT_W      = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both master ports and the shared memory bus seen by the arbiter.
interface mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          req0, rnw0, gnt0, ack0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0, rdata0;
    logic          req1, rnw1, gnt1, ack1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1, rdata1;
    logic          mem_rq, mem_rnw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    modport slave (
        input  req0, rnw0, addr0, wdata0, req1, rnw1, addr1, wdata1, mem_rdata,
        output gnt0, ack0, rdata0, gnt1, ack1, rdata1,
        output mem_rq, mem_rnw, mem_addr, mem_wdata
    );

    modport master (
        output req0, rnw0, addr0, wdata0, req1, rnw1, addr1, wdata1, mem_rdata,
        input  gnt0, ack0, rdata0, gnt1, ack1, rdata1,
        input  mem_rq, mem_rnw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that was not served last.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick,
    output logic any
);
    assign any  = req0 | req1;
    assign pick = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between the core (port 0) and the loader (port 1): latches the winning
// request, holds mem_rq for WAIT_STATES+1 cycles, then returns a one-cycle ack with read data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int AW          = 12,
    parameter int DW          = 16
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.slave  bus
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

    arb_state_t        state_reg, state_next;
    logic              sel_reg, last_reg;
    logic [AW-1:0]     addr_reg;
    logic [DW-1:0]     wdata_reg;
    logic              rnw_reg;
    logic [WAIT_W-1:0] cnt_reg;
    logic              pick, any_req;
    logic [1:0]        gnt_vec, ack_vec;
    logic              mem_rq_next;
    logic              last_access;

    rr_pick2 u_pick (
        .req0 (bus.req0),
        .req1 (bus.req1),
        .last (last_reg),
        .pick (pick),
        .any  (any_req)
    );

    assign last_access = (state_reg == ACCESS) && (cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        gnt_vec     = 2'b00;
        ack_vec     = 2'b00;
        mem_rq_next = 1'b0;
        case (state_reg)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS: begin
                mem_rq_next = 1'b1;
                if (cnt_reg == '0) state_next = DONE;
            end
            DONE: begin
                ack_vec[sel_reg] = 1'b1;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state_reg != IDLE) gnt_vec[sel_reg] = 1'b1;
    end

    // Address/data are captured once at grant so mid-access changes by the master are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg   <= PORT_CORE;
            last_reg  <= PORT_LOADER;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rnw_reg   <= 1'b1;
            cnt_reg   <= '0;
        end else if (state_reg == IDLE && any_req) begin
            sel_reg   <= pick;
            last_reg  <= pick;
            addr_reg  <= pick ? bus.addr1  : bus.addr0;
            wdata_reg <= pick ? bus.wdata1 : bus.wdata0;
            rnw_reg   <= pick ? bus.rnw1   : bus.rnw0;
            cnt_reg   <= WAIT_INIT;
        end else if (state_reg == ACCESS && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DW-1:0] rdata_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    rdata_reg <= '0;
                else if (last_access && rnw_reg && sel_reg == 1'(gi))
                    rdata_reg <= bus.mem_rdata;
            end
        end
    endgenerate

    assign bus.gnt0      = gnt_vec[0];
    assign bus.gnt1      = gnt_vec[1];
    assign bus.ack0      = ack_vec[0];
    assign bus.ack1      = ack_vec[1];
    assign bus.rdata0    = g_port[0].rdata_reg;
    assign bus.rdata1    = g_port[1].rdata_reg;
    assign bus.mem_rq    = mem_rq_next;
    assign bus.mem_rnw   = rnw_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;

endmodule
